tt_um_load_ctrl: RTL and testbench
==================================

// Module: tt_um_load_ctrl
// PURPOSE
//   Sequencer for the ternary weight shift-loader and the MAC datapath behind it. Host streams
//   MAX_OUT_LEN weight rows (loader shifts one row per ena), then activation vectors; for each
//   accepted activation the block sequences MAX_OUT_LEN serialized output slots (one per row).
//   Owns the ena of the loader, the activation latch strobe and output-mux select/valid.
// PARAMETERS
//   MAX_IN_LEN   8  ternary elements per row word
//   MAX_OUT_LEN  4  rows held by loader = outputs per activation; must be >= 2
//   WIDTH        2  bits per ternary element (informational; sets bus width only)
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   begin (re)load of weight set; level sampled each cycle
//   in_valid     in   1   host word (row or activation) present on shared bus
//   in_ready     out  1   word accepted this cycle when in_valid && in_ready
//   load_ena     out  1   loader shift enable (combinational, same cycle as accept)
//   act_latch    out  1   datapath latches activation vector (combinational)
//   out_valid    out  1   registered; output slot out_sel is valid
//   out_sel      out  CW  registered row select, CW = $clog2(MAX_OUT_LEN)
//   out_last     out  1   registered; out_valid on final slot (out_sel == MAX_OUT_LEN-1)
//   weights_ok   out  1   registered; full weight set loaded and unchanged since
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, row_cnt=0, out_sel=0, out_valid=0, out_last=0, weights_ok=0.
//   States: IDLE, LOAD, RUN, DRAIN (2-bit encoded).
//   in_ready = (state==LOAD || state==RUN) && !start.
//   load_ena = in_valid && in_ready && state==LOAD.  act_latch = in_valid && in_ready && state==RUN.
//   IDLE : start -> LOAD, row_cnt<=0, weights_ok<=0. Otherwise hold.
//   LOAD : each load_ena increments row_cnt; on accept with row_cnt==MAX_OUT_LEN-1 -> RUN,
//          row_cnt<=0, weights_ok<=1 (visible the cycle after the last loader shift).
//          in_valid low = stall, no timeout; row_cnt holds.
//   RUN  : act_latch -> DRAIN, out_valid<=1, out_sel<=0 next cycle. Idle otherwise.
//   DRAIN: in_ready=0; out_sel increments each cycle while out_valid=1; out_last=1 when
//          out_sel==MAX_OUT_LEN-1; after that slot out_valid<=0, out_last<=0, out_sel<=0, -> RUN.
//          Output latency: activation accept at cycle T -> slot k valid at T+1+k.
//          Back-to-back activations: one RUN bubble cycle between drains (throughput
//          1 activation per MAX_OUT_LEN+1 cycles).
//   start has priority over everything in every state: -> LOAD, row_cnt<=0, weights_ok<=0,
//          out_valid<=0, out_last<=0, out_sel<=0; a coincident in_valid is NOT accepted
//          (in_ready=0, no load_ena/act_latch). start held high keeps block in LOAD, row_cnt=0.
//   Partial load aborted by start discards row_cnt; loader contents are don't-care until
//          weights_ok=1.
//   Reset asserted mid-LOAD or mid-DRAIN: outputs clear immediately (async), IDLE on release.
//   row_cnt, out_sel wrap only via explicit clear; never count past MAX_OUT_LEN-1.
//   busy = (state != IDLE), combinational from state register.
// TESTING
//   1 Reset: rst=1 mid-DRAIN -> out_valid,out_last,weights_ok,busy =0 same cycle; IDLE after release.
//   2 Load: start 1 cycle, then in_valid=1 for 4 cycles -> load_ena high exactly 4 cycles,
//     weights_ok=1 the cycle after the 4th, state RUN.
//   3 Stall: load with in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 load_ena, weights_ok after 7th.
//   4 Drain: in RUN, one in_valid -> act_latch 1 cycle; out_sel 0,1,2,3 on next 4 cycles with
//     out_valid=1, out_last only on 3; in_ready=0 during those 4 cycles, 1 again after.
//   5 Back-to-back: in_valid held 1 in RUN for 12 cycles -> act_latch at cycles 0,5,10;
//     out_valid never gaps within a drain.
//   6 Restart: start asserted on 2nd DRAIN slot with in_valid=1 -> out_valid=0 next cycle,
//     no act_latch/load_ena that cycle, weights_ok=0, LOAD with row_cnt=0.

Source files
------------

// File: rtl/tt_um_load_ctrl_if.sv
// tt_um_load_ctrl_if: host/loader handshake and output-slot signals of the load sequencer.
interface tt_um_load_ctrl_if #(parameter int MAX_OUT_LEN = 4);
  localparam int CW = $clog2(MAX_OUT_LEN);
  logic start, in_valid, in_ready, load_ena, act_latch, out_valid, out_last, weights_ok, busy;
  logic [CW-1:0] out_sel;
  modport master(output start, in_valid,
                 input in_ready, load_ena, act_latch, out_valid, out_sel, out_last, weights_ok, busy);
  modport slave(input start, in_valid,
                output in_ready, load_ena, act_latch, out_valid, out_sel, out_last, weights_ok, busy);
endinterface

// File: rtl/tt_um_load_ctrl.sv
// tt_um_load_ctrl: sequences weight-row loading, activation latching and serialized output slots.
module tt_um_load_ctrl #(
  parameter int MAX_IN_LEN  = 8,
  parameter int MAX_OUT_LEN = 4,
  parameter int WIDTH       = 2
) (
  input logic clk,
  input logic rst,
  tt_um_load_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_OUT_LEN);
  localparam logic [CW-1:0] LAST = CW'(MAX_OUT_LEN - 1);
  if (MAX_OUT_LEN < 2 || MAX_IN_LEN < 1 || WIDTH < 1) begin : g_bad
    $error("tt_um_load_ctrl: MAX_OUT_LEN must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] row_cnt;
  logic acc, le, al;
  assign bus.in_ready = (state == LOAD || state == RUN) && !bus.start;
  assign acc = bus.in_valid && bus.in_ready;
  assign le = acc && state == LOAD;
  assign al = acc && state == RUN;
  assign bus.load_ena = le;
  assign bus.act_latch = al;
  assign bus.busy = state != IDLE;
  // start wins over every state and suppresses the coincident accept via in_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row_cnt <= '0;
      bus.out_sel <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.weights_ok <= 1'b0;
    end else if (bus.start) begin
      state <= LOAD;
      row_cnt <= '0;
      bus.out_sel <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.weights_ok <= 1'b0;
    end else begin
      case (state)
        LOAD: if (le) begin
          if (row_cnt == LAST) begin
            state <= RUN;
            row_cnt <= '0;
            bus.weights_ok <= 1'b1;
          end else row_cnt <= row_cnt + 1'b1;
        end
        RUN: if (al) begin
          state <= DRAIN;
          bus.out_valid <= 1'b1;
          bus.out_sel <= '0;
        end
        DRAIN: if (bus.out_sel == LAST) begin
          state <= RUN;
          bus.out_valid <= 1'b0;
          bus.out_last <= 1'b0;
          bus.out_sel <= '0;
        end else begin
          bus.out_sel <= bus.out_sel + 1'b1;
          bus.out_last <= CW'(bus.out_sel + 1'b1) == LAST;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_um_load_ctrl.sv
// tb_tt_um_load_ctrl: directed and random scenarios checked against a row/slot counting model.
module tb_tt_um_load_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit m_on;
  int m_rows, m_slot;
  logic m_start, m_valid;
  always #5 clk = ~clk;
  tt_um_load_ctrl_if #(.MAX_OUT_LEN(N)) bus();
  tt_um_load_ctrl #(.MAX_IN_LEN(8), .MAX_OUT_LEN(N), .WIDTH(2)) dut(.clk(clk), .rst(rst), .bus(bus));

  // {in_ready, load_ena, act_latch, out_valid, out_sel, out_last, weights_ok, busy}
  function automatic logic [8:0] expv();
    logic r;
    r = !m_start && m_on && m_slot < 0;
    return {r, m_valid && r && m_rows < N, m_valid && r && m_rows == N, m_slot >= 0,
            2'(m_slot < 0 ? 0 : m_slot), m_slot == N - 1, m_rows == N, m_on};
  endfunction

  function automatic logic [8:0] obsv();
    return {bus.in_ready, bus.load_ena, bus.act_latch, bus.out_valid, bus.out_sel,
            bus.out_last, bus.weights_ok, bus.busy};
  endfunction

  task automatic model_reset();
    m_on = 0; m_rows = 0; m_slot = -1;
  endtask

  task automatic drive(input logic s, input logic v);
    @(negedge clk);
    bus.start = s; bus.in_valid = v; m_start = s; m_valid = v;
    #1;
  endtask

  task automatic tick();
    logic [8:0] e;
    e = expv();
    @(posedge clk);
    if (rst) model_reset();
    else if (m_start) begin m_on = 1; m_rows = 0; m_slot = -1; end
    else if (e[7]) m_rows++;
    else if (e[6]) m_slot = 0;
    else if (m_slot >= 0) m_slot = (m_slot == N - 1) ? -1 : m_slot + 1;
  endtask

  task automatic load_all();
    drive(1, 0); tick();
    repeat (N) begin drive(0, 1); tick(); end
  endtask

  task automatic test_reset();
    drive(0, 0);
    tests++;
    if (obsv() !== 9'b0) begin fails++; $display("FAIL reset_state got=%b want=%b", obsv(), 9'b0); end
    @(negedge clk); rst = 0;
    drive(0, 1);
    tests++;
    if (obsv() !== expv()) begin fails++; $display("FAIL idle got=%b want=%b", obsv(), expv()); end
    tick();
    load_all();
    drive(0, 1); tick();
    drive(0, 0); tick();
    drive(0, 1);
    rst = 1; #1;
    tests++;
    if (obsv() !== 9'b0) begin fails++; $display("FAIL reset_mid_drain got=%b want=%b", obsv(), 9'b0); end
    model_reset(); tick();
    @(negedge clk); rst = 0;
    drive(0, 0);
    tests++;
    if (obsv() !== 9'b0) begin fails++; $display("FAIL reset_release got=%b want=%b", obsv(), 9'b0); end
    tick();
  endtask

  task automatic test_load();
    int n = 0;
    drive(1, 1);
    tests++;
    if (obsv() !== expv()) begin fails++; $display("FAIL load_start got=%b want=%b", obsv(), expv()); end
    tick();
    repeat (N) begin
      drive(0, 1);
      n += int'(bus.load_ena);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL load got=%b want=%b", obsv(), expv()); end
      tick();
    end
    drive(0, 0);
    tests++;
    if (n !== 4 || bus.weights_ok !== 1'b1 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL load_done ena=%0d ok=%b rdy=%b want 4 1 1", n, bus.weights_ok, bus.in_ready);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [6:0] pat = 7'b1011001;
    int n = 0;
    drive(1, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, pat[i]);
      n += int'(bus.load_ena);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL stall c%0d got=%b want=%b", i, obsv(), expv()); end
      tick();
    end
    drive(0, 0);
    tests++;
    if (n !== 4 || bus.weights_ok !== 1'b1) begin
      fails++; $display("FAIL stall_done ena=%0d ok=%b want 4 1", n, bus.weights_ok);
    end
    tick();
  endtask

  task automatic test_drain();
    int nv = 0, nl = 0, na = 0;
    for (int i = 0; i < 7; i++) begin
      drive(0, i == 0);
      na += int'(bus.act_latch); nv += int'(bus.out_valid); nl += int'(bus.out_last);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL drain c%0d got=%b want=%b", i, obsv(), expv()); end
      tick();
    end
    tests++;
    if (na !== 1 || nv !== 4 || nl !== 1) begin
      fails++; $display("FAIL drain_counts act=%0d valid=%0d last=%0d want 1 4 1", na, nv, nl);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    for (int c = 0; c < 12; c++) begin
      drive(0, 1);
      if (bus.act_latch) q.push_back(c);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL b2b c%0d got=%b want=%b", c, obsv(), expv()); end
      tick();
    end
    tests++;
    if (q.size() != 3 || q[0] != 0 || q[1] != 5 || q[2] != 10) begin
      fails++; $display("FAIL b2b_act got=%p want 0 5 10", q);
    end
    repeat (4) begin drive(0, 0); tick(); end
  endtask

  task automatic test_restart();
    drive(0, 1); tick();
    drive(0, 0); tick();
    drive(1, 1);
    tests++;
    if (bus.out_sel !== 2'd1 || bus.in_ready || bus.load_ena || bus.act_latch || obsv() !== expv()) begin
      fails++; $display("FAIL restart_edge got=%b want=%b", obsv(), expv());
    end
    tick();
    for (int i = 0; i < N + 1; i++) begin
      drive(0, i < N);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL restart c%0d got=%b want=%b", i, obsv(), expv()); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      tests++;
      if (obsv() !== expv()) begin fails++; $display("FAIL random c%0d got=%b want=%b", i, obsv(), expv()); end
      tick();
    end
  endtask

  initial begin
    bus.start = 0; bus.in_valid = 0; m_start = 0; m_valid = 0;
    model_reset();
    test_reset();
    test_load();
    test_drain();
    test_back_to_back();
    test_stall();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
